controle_pagamento: RTL and testbench
=====================================

Name: controle_pagamento

Overview:
- Payment and change sequencer for the vending machine. Runs while the main controller is in its compare phase.
- Collects coins against a latched product price and requests product release from the dispenser.
- Returns change (or a refund) coin by coin through the coin ejector, using greedy denomination selection.
- Signals completion to the main controller with a one-cycle OK pulse.

Parameters:
- LARGURA_VALOR, 8: width of price, coin value, credit and remainder (units = cents).
- TIMEOUT_CICLOS, 1000: idle cycles in COLETA without an accepted coin before auto-cancel. Timer width is $clog2(TIMEOUT_CICLOS+1).
- MOEDA_A, 25: largest change denomination.
- MOEDA_B, 10: middle change denomination.
- MOEDA_C, 5: smallest change denomination. Requires MOEDA_A > MOEDA_B > MOEDA_C > 0.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- iniciar  in  1  start pulse from main controller; price is valid on preco this cycle.
- preco  in  LARGURA_VALOR  product price, sampled on iniciar.
- moedaValida  in  1  one-cycle pulse: coin inserted.
- valorMoeda  in  LARGURA_VALOR  value of the inserted coin.
- cancelar  in  1  user cancel.
- liberaPronto  in  1  dispenser acknowledge.
- trocoPronto  in  1  coin ejector acknowledge.
- OK  out  1  one-cycle transaction-done pulse.
- credito  out  LARGURA_VALOR  accumulated credit.
- liberaProduto  out  1  product release request.
- ejetaMoeda  out  1  change coin request.
- moedaTroco  out  2  denomination select: 0=A, 1=B, 2=C.
- erro  out  1  one-cycle error pulse.
- estado  out  3  current state code.

Behaviour:
- Outputs: all registered. Reset values: every output 0, estado=OCIOSO, internal precoReg/restante/timer = 0.
- States: OCIOSO=0, COLETA=1, LIBERA=2, TROCO=3, FIM=4. Codes 5-7 go to OCIOSO next cycle.
- Reset: rst has priority over all inputs at any point in a transaction. The cycle after rst: OCIOSO, all outputs 0, pending requests dropped, credit discarded.
- OCIOSO:
  - iniciar=1 → latch preco into precoReg, clear timer, go to COLETA. estado=1 on the next cycle.
  - If preco==0 → go to LIBERA instead.
  - Coins and cancelar are ignored here.
- COLETA:
  - Accepting a coin: moedaValida → credito += valorMoeda, timer reloads.
  - Rejecting a coin: if the sum exceeds 2^LARGURA_VALOR-1, the coin is rejected: credito unchanged, erro=1 for one cycle.
  - The timer increments each cycle without an accepted coin.
  - Priority, evaluated on registered values each cycle: (1) credito>=precoReg → LIBERA; (2) cancelar, or timer==TIMEOUT_CICLOS → restante=credito, go to TROCO.
  - Coin and cancelar in the same cycle: the coin is accepted first, then the cancel applies, so the refund includes that coin.
  - A coin arriving in the cycle credito reaches price is still accepted and returned as change.
- LIBERA:
  - liberaProduto=1, held until liberaPronto is sampled high.
  - Next cycle: liberaProduto=0, restante=credito-precoReg, go to TROCO.
  - cancelar and coins are ignored.
- TROCO:
  - restante==0 → go to FIM.
  - Otherwise select the largest denomination ≤ restante. Drive ejetaMoeda=1 with moedaTroco stable until trocoPronto.
  - Ack sampled in cycle k: at k+1 ejetaMoeda=0 and restante -= denomination; at k+2 at the earliest, the next request.
  - 0 < restante < MOEDA_C → remainder forfeited, erro=1 for one cycle, go to FIM.
  - trocoPronto while ejetaMoeda=0 is ignored.
- FIM: OK=1 for exactly one cycle, credito=0, restante=0, go to OCIOSO.
- iniciar outside OCIOSO is ignored.

Test Plan:
1. iniciar with preco=30; coins 25 then 10 → credito 25 then 35, LIBERA, liberaProduto=1. Ack → one coin moedaTroco=2 (5). Ack → OK pulse, credito=0.
2. preco=25, coin 25 → LIBERA. Ack → TROCO with restante=0 → FIM, OK pulse, ejetaMoeda never asserted.
3. preco=50, coin 10, then cancelar → refund of one moedaTroco=1 coin. liberaProduto never 1. OK pulse.
4. TIMEOUT_CICLOS=16, preco=100, coins 25+25, then 16 idle cycles → TROCO, two moedaTroco=0 ejections, OK pulse.
5. credito=250, coin 25 → erro pulse, credito stays 250. Separately, preco=3 with a coin of 10 → change 5, remainder 2 forfeited, erro pulse, then OK.
6. rst asserted in TROCO while ejetaMoeda=1 → next cycle estado=0 and all outputs 0. A later trocoPronto has no effect.

Source files
------------

// File: rtl/controle_pagamento.sv
// Purpose: vending-machine payment sequencer: collects coins against a latched price, requests release, pays greedy change.
// Latency: state and outputs update one cycle after the sampled input; a change coin needs at least two cycles per request.
// Backpressure: liberaProduto/ejetaMoeda stay high until liberaPronto/trocoPronto is sampled; acks without a request are ignored.
module controle_pagamento #(
  parameter int LARGURA_VALOR  = 8,
  parameter int TIMEOUT_CICLOS = 1000,
  parameter int MOEDA_A        = 25,
  parameter int MOEDA_B        = 10,
  parameter int MOEDA_C        = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iniciar,
  input  logic [LARGURA_VALOR-1:0] preco,
  input  logic                     moedaValida,
  input  logic [LARGURA_VALOR-1:0] valorMoeda,
  input  logic                     cancelar,
  input  logic                     liberaPronto,
  input  logic                     trocoPronto,
  output logic                     OK,
  output logic [LARGURA_VALOR-1:0] credito,
  output logic                     liberaProduto,
  output logic                     ejetaMoeda,
  output logic [1:0]               moedaTroco,
  output logic                     erro,
  output logic [2:0]               estado
);

  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [LARGURA_VALOR-1:0] VA = LARGURA_VALOR'(MOEDA_A);
  localparam logic [LARGURA_VALOR-1:0] VB = LARGURA_VALOR'(MOEDA_B);
  localparam logic [LARGURA_VALOR-1:0] VC = LARGURA_VALOR'(MOEDA_C);

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    COLETA = 3'd1,
    LIBERA = 3'd2,
    TROCO  = 3'd3,
    FIM    = 3'd4
  } estado_t;

  estado_t                  estado_q;
  logic [LARGURA_VALOR-1:0] preco_q;
  logic [LARGURA_VALOR-1:0] credito_q;
  logic [LARGURA_VALOR-1:0] restante_q;
  logic [TW-1:0]            timer_q;
  logic                     ok_q;
  logic                     erro_q;
  logic                     libera_q;
  logic                     ejeta_q;
  logic [1:0]               moeda_q;

  logic [LARGURA_VALOR:0]   soma;
  logic                     aceita;
  logic [LARGURA_VALOR-1:0] credito_d;
  logic [1:0]               moeda_d;
  logic [LARGURA_VALOR-1:0] valor_ejetado;

  // Coin acceptance (overflow rejects the coin), greedy denomination pick and value of the coin being ejected
  always_comb begin
    soma      = {1'b0, credito_q} + {1'b0, valorMoeda};
    aceita    = moedaValida && !soma[LARGURA_VALOR];
    credito_d = aceita ? soma[LARGURA_VALOR-1:0] : credito_q;

    moeda_d = 2'd2;
    if (restante_q >= VA) begin
      moeda_d = 2'd0;
    end else if (restante_q >= VB) begin
      moeda_d = 2'd1;
    end

    case (moeda_q)
      2'd0:    valor_ejetado = VA;
      2'd1:    valor_ejetado = VB;
      default: valor_ejetado = VC;
    endcase
  end

  // Transaction FSM with all outputs registered; OK and erro default low so they only ever pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q   <= OCIOSO;
      preco_q    <= '0;
      credito_q  <= '0;
      restante_q <= '0;
      timer_q    <= '0;
      ok_q       <= 1'b0;
      erro_q     <= 1'b0;
      libera_q   <= 1'b0;
      ejeta_q    <= 1'b0;
      moeda_q    <= 2'd0;
    end else begin
      ok_q   <= 1'b0;
      erro_q <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          if (iniciar) begin
            preco_q   <= preco;
            timer_q   <= '0;
            credito_q <= '0;
            if (preco == '0) begin
              estado_q <= LIBERA;
              libera_q <= 1'b1;
            end else begin
              estado_q <= COLETA;
            end
          end
        end
        COLETA: begin
          // A coin is taken even in the cycle the exit is decided; it ends up in the change or refund
          credito_q <= credito_d;
          if (moedaValida && !aceita) begin
            erro_q <= 1'b1;
          end
          timer_q <= aceita ? '0 : timer_q + TW'(1);
          if (credito_q >= preco_q) begin
            estado_q <= LIBERA;
            libera_q <= 1'b1;
          end else if (cancelar || (timer_q == TW'(TIMEOUT_CICLOS))) begin
            restante_q <= credito_d;
            estado_q   <= TROCO;
          end
        end
        LIBERA: begin
          if (liberaPronto) begin
            libera_q   <= 1'b0;
            restante_q <= credito_q - preco_q;
            estado_q   <= TROCO;
          end
        end
        TROCO: begin
          if (ejeta_q) begin
            if (trocoPronto) begin
              ejeta_q    <= 1'b0;
              restante_q <= restante_q - valor_ejetado;
            end
          end else if (restante_q == '0) begin
            estado_q  <= FIM;
            ok_q      <= 1'b1;
            credito_q <= '0;
          end else if (restante_q < VC) begin
            // Remainder below the smallest coin cannot be paid out
            erro_q     <= 1'b1;
            estado_q   <= FIM;
            ok_q       <= 1'b1;
            credito_q  <= '0;
            restante_q <= '0;
          end else begin
            ejeta_q <= 1'b1;
            moeda_q <= moeda_d;
          end
        end
        FIM: begin
          credito_q  <= '0;
          restante_q <= '0;
          estado_q   <= OCIOSO;
        end
        default: begin
          estado_q <= OCIOSO;
        end
      endcase
    end
  end

  assign OK            = ok_q;
  assign credito       = credito_q;
  assign liberaProduto = libera_q;
  assign ejetaMoeda    = ejeta_q;
  assign moedaTroco    = moeda_q;
  assign erro          = erro_q;
  assign estado        = estado_q;

endmodule

// File: tb/tb_controle_pagamento.sv
// Purpose: self-checking bench for controle_pagamento: directed scenarios plus random purchases/cancels against a payment model.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point after the next edge.
// Backpressure: the bench plays dispenser and ejector, acknowledging requests after random delays.
module tb_controle_pagamento;

  localparam int W   = 8;
  localparam int TO  = 16;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         iniciar = 1'b0;
  logic [W-1:0] preco = '0;
  logic         moedaValida = 1'b0;
  logic [W-1:0] valorMoeda = '0;
  logic         cancelar = 1'b0;
  logic         liberaPronto = 1'b0;
  logic         trocoPronto = 1'b0;
  logic         OK;
  logic [W-1:0] credito;
  logic         liberaProduto;
  logic         ejetaMoeda;
  logic [1:0]   moedaTroco;
  logic         erro;
  logic [2:0]   estado;

  controle_pagamento #(
    .LARGURA_VALOR(W), .TIMEOUT_CICLOS(TO), .MOEDA_A(25), .MOEDA_B(10), .MOEDA_C(5)
  ) dut (
    .clk(clk), .rst(rst), .iniciar(iniciar), .preco(preco),
    .moedaValida(moedaValida), .valorMoeda(valorMoeda), .cancelar(cancelar),
    .liberaPronto(liberaPronto), .trocoPronto(trocoPronto), .OK(OK),
    .credito(credito), .liberaProduto(liberaProduto), .ejetaMoeda(ejetaMoeda),
    .moedaTroco(moedaTroco), .erro(erro), .estado(estado)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int got_q[$];
  int exp_q[$];
  int n_erro;
  int saw_lib;
  int ok_cred;
  int done;
  int model_cred;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Greedy change model: denomination codes 0=25, 1=10, 2=5; returns 1 if a remainder is forfeited
  task automatic model_troco(input int r, output int forfeit);
    int rem;
    exp_q = {};
    rem = r;
    while (rem >= 5) begin
      if (rem >= 25) begin exp_q.push_back(0); rem -= 25; end
      else if (rem >= 10) begin exp_q.push_back(1); rem -= 10; end
      else begin exp_q.push_back(2); rem -= 5; end
    end
    forfeit = (rem > 0) ? 1 : 0;
  endtask

  task automatic start(input int p);
    iniciar = 1'b1;
    preco   = W'(p);
    tick();
    iniciar = 1'b0;
    preco   = '0;
    chk("start_estado", estado, (p == 0) ? 2 : 1);
    model_cred = 0;
  endtask

  task automatic coin(input int v, input string tag);
    moedaValida = 1'b1;
    valorMoeda  = W'(v);
    tick();
    moedaValida = 1'b0;
    if (model_cred + v > MAXV) begin
      chk({tag, "_rej_erro"}, erro, 1);
    end else begin
      model_cred += v;
      chk({tag, "_erro"}, erro, 0);
    end
    chk({tag, "_cred"}, credito, model_cred);
  endtask

  // Acts as dispenser and ejector until the OK pulse (bounded)
  task automatic run_txn();
    got_q   = {};
    n_erro  = 0;
    saw_lib = 0;
    ok_cred = -1;
    done    = 0;
    for (int c = 0; c < 600 && done == 0; c++) begin
      if (erro) n_erro++;
      if (liberaProduto) saw_lib = 1;
      if (OK) begin
        done    = 1;
        ok_cred = int'(credito);
      end
      liberaPronto = 1'b0;
      trocoPronto  = 1'b0;
      if (done == 0) begin
        if (liberaProduto && ($urandom_range(0, 1) == 1)) liberaPronto = 1'b1;
        if (ejetaMoeda && ($urandom_range(0, 2) != 0)) begin
          trocoPronto = 1'b1;
          got_q.push_back(int'(moedaTroco));
        end
        tick();
      end
    end
    liberaPronto = 1'b0;
    trocoPronto  = 1'b0;
  endtask

  task automatic expect_end(input string tag, input int r, input int lib);
    int forfeit;
    model_troco(r, forfeit);
    run_txn();
    chk({tag, "_ok_seen"}, done, 1);
    chk({tag, "_libera"}, saw_lib, lib);
    chk({tag, "_ncoins"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk({tag, "_coin"}, (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
    end
    chk({tag, "_erro_cnt"}, n_erro, forfeit);
    chk({tag, "_ok_cred"}, ok_cred, 0);
    tick();
    chk({tag, "_ok_1cyc"}, OK, 0);
    chk({tag, "_back_idle"}, estado, 0);
  endtask

  initial begin : main
    int n;
    int p;
    int do_cancel;
    int ncoins;
    int stop_early;
    int vals[5];
    vals = '{5, 10, 25, 50, 100};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_estado", estado, 0);
    chk("rst_cred", credito, 0);
    chk("rst_ok", OK, 0);
    chk("rst_lib", liberaProduto, 0);
    chk("rst_ej", ejetaMoeda, 0);
    chk("rst_erro", erro, 0);
    chk("rst_moeda", moedaTroco, 0);

    // Coins and cancel ignored while idle
    moedaValida = 1'b1; valorMoeda = 8'd50; cancelar = 1'b1;
    tick();
    moedaValida = 1'b0; cancelar = 1'b0;
    chk("idle_coin_cred", credito, 0);
    chk("idle_coin_estado", estado, 0);

    // 1: price 30, coins 25+10, change one 5; iniciar ignored mid-transaction
    start(30);
    coin(25, "t1_c25");
    tick();
    chk("t1_still_coleta", estado, 1);
    iniciar = 1'b1; preco = '0;
    tick();
    iniciar = 1'b0;
    chk("t1_iniciar_ignored", estado, 1);
    chk("t1_iniciar_cred", credito, 25);
    coin(10, "t1_c10");
    tick();
    chk("t1_libera_estado", estado, 2);
    chk("t1_libera_req", liberaProduto, 1);
    expect_end("t1", 5, 1);

    // 2: exact payment, no change
    start(25);
    coin(25, "t2_c25");
    tick();
    chk("t2_libera", estado, 2);
    expect_end("t2", 0, 1);

    // 3: cancel refunds the credit
    start(50);
    coin(10, "t3_c10");
    tick();
    cancelar = 1'b1;
    tick();
    cancelar = 1'b0;
    chk("t3_troco", estado, 3);
    expect_end("t3", 10, 0);

    // 4: inactivity timeout refunds 50 as two 25s
    start(100);
    coin(25, "t4_c25a");
    coin(25, "t4_c25b");
    n = 0;
    while (estado != 3'd3 && n < 40) begin
      tick();
      n++;
    end
    chk("t4_timeout_reached", estado, 3);
    chk("t4_not_early", (n >= TO) ? 1 : 0, 1);
    chk("t4_not_late", (n <= TO + 1) ? 1 : 0, 1);
    expect_end("t4", 50, 0);

    // 5a: credit 250, coin 25 overflows and is rejected
    start(255);
    for (int i = 0; i < 10; i++) coin(25, "t5_fill");
    coin(25, "t5_ovf");
    coin(5, "t5_c5");
    tick();
    chk("t5_libera", estado, 2);
    expect_end("t5a", 0, 1);

    // 5b: price 3, coin 10: change 5, remainder 2 forfeited with erro
    start(3);
    coin(10, "t5b_c10");
    tick();
    expect_end("t5b", 7, 1);

    // Coin and cancel in the same cycle: the coin joins the refund
    start(50);
    coin(10, "cc_c10");
    tick();
    moedaValida = 1'b1; valorMoeda = 8'd25; cancelar = 1'b1;
    tick();
    moedaValida = 1'b0; cancelar = 1'b0;
    chk("cc_troco", estado, 3);
    chk("cc_cred", credito, 35);
    expect_end("cc", 35, 0);

    // Coin arriving as the price is reached is accepted and returned
    start(30);
    coin(25, "lc_c25");
    tick();
    coin(10, "lc_c10");
    coin(5, "lc_c5");
    chk("lc_libera", estado, 2);
    expect_end("lc", 10, 1);

    // 6: reset while a change coin is requested
    start(10);
    coin(25, "t6_c25");
    tick();
    liberaPronto = 1'b1;
    tick();
    liberaPronto = 1'b0;
    n = 0;
    while (ejetaMoeda !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("t6_ejeta_req", ejetaMoeda, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_estado", estado, 0);
    chk("t6_rst_ej", ejetaMoeda, 0);
    chk("t6_rst_cred", credito, 0);
    chk("t6_rst_lib", liberaProduto, 0);
    chk("t6_rst_ok", OK, 0);
    chk("t6_rst_erro", erro, 0);
    chk("t6_rst_moeda", moedaTroco, 0);
    trocoPronto = 1'b1;
    tick();
    trocoPronto = 1'b0;
    chk("t6_late_ack_estado", estado, 0);
    chk("t6_late_ack_ej", ejetaMoeda, 0);
    chk("t6_late_ack_ok", OK, 0);

    // Random purchases and cancels against the model
    for (int t = 0; t < 30; t++) begin
      p = $urandom_range(0, 150);
      do_cancel = ($urandom_range(0, 3) == 0) ? 1 : 0;
      start(p);
      if (p == 0) begin
        expect_end("rnd_free", 0, 1);
      end else begin
        ncoins = 0;
        stop_early = 0;
        while (model_cred < p && stop_early == 0) begin
          if (do_cancel == 1 && ncoins >= 1 && $urandom_range(0, 1) == 1) begin
            stop_early = 1;
          end else begin
            coin(vals[$urandom_range(0, 4)], "rnd_coin");
            ncoins++;
            tick();
            chk("rnd_estado", estado, (model_cred >= p) ? 2 : 1);
          end
        end
        if (model_cred < p) begin
          cancelar = 1'b1;
          tick();
          cancelar = 1'b0;
          chk("rnd_cancel_troco", estado, 3);
          expect_end("rnd_cancel", model_cred, 0);
        end else begin
          expect_end("rnd_buy", model_cred - p, 1);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
